// File: rtl/alu_share_pkg.sv
// alu_share_pkg: ALU opcodes, FSM encoding and helpers for alu_share_arbiter.
// Optional macro ALU_SHARE_ILLEGAL_OP_EN uses is_illegal_op().
package alu_share_pkg;

  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_SUB        = 4'd1;
  localparam logic [3:0] OP_AND        = 4'd2;
  localparam logic [3:0] OP_OR         = 4'd3;
  localparam logic [3:0] OP_XOR        = 4'd4;
  localparam logic [3:0] OP_SLL        = 4'd5;
  localparam logic [3:0] OP_SRL        = 4'd6;
  localparam logic [3:0] OP_SRA        = 4'd7;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_illegal_op(input logic [3:0] sel);
    return sel > OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_last+1.
// Ports: i_req (request vector), i_last (previous grant), o_grant (one-hot), o_idx, o_any.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IW'((int'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU among NUM_REQ requesters (RR grant,
// operand latch, registered result on a valid/ready response tagged by ID).
// Ports: clk, rst (async high), req_* (packed per requester), alu_* (to/from
// ALU), rsp_* (response channel), busy. Macro ALU_SHARE_ILLEGAL_OP_EN adds
// rsp_err and a short IDLE->RESP path for sel >= 8.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_sel,
  input  logic [NUM_REQ*5-1:0]  req_shamt,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_sel,
  output logic [4:0]           alu_shamt,
  input  logic [31:0]          alu_out,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_zero,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef ALU_SHARE_ILLEGAL_OP_EN
  ,
  output logic                 rsp_err
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t r_state, w_next;

  logic [IW-1:0]      r_last;
  logic [IW-1:0]      w_gidx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic               w_accept;
  logic               w_illegal;

  logic [31:0]     r_a, r_b, r_data;
  logic [3:0]      r_sel;
  logic [4:0]      r_shamt;
  logic            r_zero;
  logic [ID_W-1:0] r_id;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
  logic            r_err;
`endif

  logic [31:0] w_a  [NUM_REQ];
  logic [31:0] w_b  [NUM_REQ];
  logic [3:0]  w_sel[NUM_REQ];
  logic [4:0]  w_sh [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_a[i]   = req_a[32*i +: 32];
    assign w_b[i]   = req_b[32*i +: 32];
    assign w_sel[i] = req_sel[4*i +: 4];
    assign w_sh[i]  = req_shamt[5*i +: 5];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;

`ifdef ALU_SHARE_ILLEGAL_OP_EN
  assign w_illegal = is_illegal_op(w_sel[w_gidx]);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_illegal ? RESP : EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant is masked during reset so no handshake is visible while rst is high.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && !rst) req_ready = w_grant;
    busy      = (r_state != IDLE);
    rsp_valid = (r_state == RESP);
    alu_a     = r_a;
    alu_b     = r_b;
    alu_sel   = r_sel;
    alu_shamt = r_shamt;
    rsp_data  = r_data;
    rsp_zero  = r_zero;
    rsp_id    = r_id;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    rsp_err   = r_err;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= IW'(NUM_REQ - 1);
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_shamt <= '0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_id    <= '0;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a     <= w_a[w_gidx];
        r_b     <= w_b[w_gidx];
        r_sel   <= w_sel[w_gidx];
        r_shamt <= w_sh[w_gidx];
        r_last  <= w_gidx;
        r_id    <= ID_W'(w_gidx);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
        r_err   <= w_illegal;
`endif
        if (w_illegal) begin
          r_data <= '0;
          r_zero <= 1'b0;
        end
      end
      if (r_state == EXEC) begin
        r_data <= alu_out;
        r_zero <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed + random transactions against a
// transaction-level reference (RR pick, ALU arithmetic, latency).
module tb_alu_share_arbiter;

  localparam int N   = 3;
  localparam int IDW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a, req_b;
  logic [N*4-1:0]    req_sel;
  logic [N*5-1:0]    req_shamt;
  logic [31:0]       alu_a, alu_b, alu_out;
  logic [3:0]        alu_sel;
  logic [4:0]        alu_shamt;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready, rsp_zero, busy;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
  logic              rsp_err;
`endif

  logic [31:0] ta[N];
  logic [31:0] tbv[N];
  logic [3:0]  ts[N];
  logic [4:0]  th[N];

  int n_chk  = 0;
  int n_pass = 0;
  int m_last;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .req_shamt (req_shamt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_shamt (alu_shamt),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  s,
                                          input logic [4:0]  sh);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $signed(a) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = ref_alu(alu_a, alu_b, alu_sel, alu_shamt);
  assign alu_zero = (alu_out == 32'd0);

  always_comb begin
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    req_shamt = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32]   = ta[i];
      req_b[32*i +: 32]   = tbv[i];
      req_sel[4*i +: 4]   = ts[i];
      req_shamt[5*i +: 5] = th[i];
    end
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] s,
                        input logic [4:0] sh);
    ta[i] = a; tbv[i] = b; ts[i] = s; th[i] = sh;
  endtask

  // Called shortly after a falling edge with the DUT idle.
  task automatic txn(input logic [N-1:0] vld, input int stall);
    int g, lat, exp_lat;
    logic [31:0] ed;
    logic ez, bad;
    req_valid = vld;
    #1;
    g = rr_pick(m_last, vld);
    chk("grant", 32'(req_ready), 32'(1 << g));
    bad = ts[g] > 4'd7;
    ed  = ref_alu(ta[g], tbv[g], ts[g], th[g]);
    ez  = (ed == 32'd0);
    exp_lat = 2;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    if (bad) begin
      ez = 1'b0;
      exp_lat = 1;
    end
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 5) begin
      chk("exec_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("data", rsp_data, ed);
    chk("zero", 32'(rsp_zero), 32'(ez));
    chk("id", 32'(rsp_id), 32'(g));
    chk("alu_a_hold", alu_a, ta[g]);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    chk("err", 32'(rsp_err), 32'(bad));
`endif
    repeat (stall) begin
      req_valid = '1;
      @(negedge clk);
      #1;
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, ed);
      chk("stall_id", 32'(rsp_id), 32'(g));
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_after", 32'(busy), 32'd0);
    m_last = g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] v;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, 32'd1, 32'd2, 4'd0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst    = 1'b0;
    m_last = N - 1;
    #1;

    set_op(0, 32'd5, 32'd3, 4'd0, 5'd0);
    txn(3'b001, 0);
    set_op(1, 32'h1234, 32'h1234, 4'd1, 5'd0);
    txn(3'b010, 0);
    set_op(0, 32'hF0, 32'h0F, 4'd3, 5'd0);
    set_op(1, 32'd1, 32'd0, 4'd5, 5'd4);
    repeat (4) txn(3'b011, 0);
    txn(3'b001, 5);
    set_op(2, 32'd7, 32'd9, 4'd9, 5'd0);
    txn(3'b100, 0);

    set_op(0, 32'd11, 32'd22, 4'd0, 5'd0);
    req_valid = 3'b011;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(rsp_valid), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_alu_a", alu_a, 32'd0);
    chk("mid_data", rsp_data, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    m_last    = N - 1;
    @(negedge clk);
    #1;
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd1, 4'd0, 5'd0);
    repeat (6) txn('1, 0);

    repeat (40) begin
      for (int i = 0; i < N; i++) begin
        ta[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                              : $urandom;
        tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
        ts[i]  = 4'($urandom_range(0, 15));
        th[i]  = 5'($urandom_range(0, 31));
      end
      v = N'($urandom_range(1, (1 << N) - 1));
      txn(v, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
